// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard resolver for the 5-stage RISC-V core.
// Handles operand forwarding, load-use stalls, branch flushes, and a
// data-memory wait FSM with a sticky timeout watchdog.
// Optional build macro HAZARD_PERF_CNT_EN adds three wrapping performance
// counters (stall cycles, load-use events, front-end flushes).
module hazard_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcb0E,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       oMemTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] oStallCycles,
    output logic [CNT_W-1:0] oLoadUseCnt,
    output logic [CNT_W-1:0] oFlushCnt
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    if (CNT_W < 1 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_params
        $error("hazard_unit: parameter out of range");
    end

    mem_state_t state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] wait_now;
    logic       release_reg, release_next;
    logic       timeout_set;
    logic       mem_stall;
    logic       lw_stall;

    // Source-match forward select; M is newer than W so it wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m,
                                           input logic [4:0] rd_m,
                                           input logic       wr_w,
                                           input logic [4:0] rd_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Forwarding selects and load-use detection.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
        ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        lw_stall  = ResultSrcb0E && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Memory-wait state register, wait counter, post-timeout release flag and sticky timeout.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_reg   <= RUN;
            cnt_reg     <= 8'd0;
            release_reg <= 1'b0;
            oMemTimeout <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            release_reg <= release_next;
            oMemTimeout <= oMemTimeout | timeout_set;
        end
    end

    // Memory-wait next state. wait_now is the number of wait cycles including
    // the current one; reaching MAX_WAIT ends the wait with a timeout. The cycle
    // right after a timeout ignores the still-pending request so the stuck
    // access is treated as complete and the pipeline moves on.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        release_next = 1'b0;
        timeout_set  = 1'b0;
        mem_stall    = 1'b0;
        wait_now     = (cnt_reg == 8'hFF) ? 8'hFF : cnt_reg + 8'd1;
        case (state_reg)
            RUN: begin
                wait_now = 8'd1;
                if (MemReqM && !MemReadyM && !release_reg && !irst) begin
                    mem_stall = 1'b1;
                    if (wait_now >= MAX_WAIT_L) begin
                        timeout_set  = 1'b1;
                        release_next = 1'b1;
                        cnt_next     = 8'd0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = wait_now;
                    end
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    state_next = RUN;
                    cnt_next   = 8'd0;
                end else begin
                    mem_stall = !irst;
                    cnt_next  = wait_now;
                    if (wait_now >= MAX_WAIT_L) begin
                        timeout_set  = 1'b1;
                        release_next = 1'b1;
                        state_next   = RUN;
                        cnt_next     = 8'd0;
                    end
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Stall/flush outputs; a memory freeze suppresses flushes because the held
    // E instruction presents PCSrcE again once released.
    always_comb begin
        StallM = mem_stall;
        StallE = mem_stall;
        StallF = mem_stall | lw_stall;
        StallD = mem_stall | lw_stall;
        FlushW = mem_stall;
        FlushE = !mem_stall && (lw_stall || PCSrcE);
        FlushD = !mem_stall && PCSrcE;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Wrapping performance counters.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            oStallCycles <= '0;
            oLoadUseCnt  <= '0;
            oFlushCnt    <= '0;
        end else begin
            if (StallF)
                oStallCycles <= oStallCycles + 1'b1;
            if (lw_stall && !mem_stall)
                oLoadUseCnt <= oLoadUseCnt + 1'b1;
            if (FlushD)
                oFlushCnt <= oFlushCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven check of forwarding/stall/flush logic plus
// hand-written sequences for memory wait, timeout, async reset and counters.
module tb_hazard_unit;

    logic       iclk = 1'b0;
    logic       irst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcb0E, PCSrcE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, oMemTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] oStallCycles, oLoadUseCnt, oFlushCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 iclk = ~iclk;

    hazard_unit #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .iclk(iclk), .irst(irst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcb0E(ResultSrcb0E), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .oMemTimeout(oMemTimeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .oStallCycles(oStallCycles), .oLoadUseCnt(oLoadUseCnt), .oFlushCnt(oFlushCnt)
`endif
    );

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    wire [10:0] outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    localparam logic [10:0] IDLE     = 11'b0000_0000000;
    localparam logic [10:0] MEM_STALL = 11'b0000_1111001;

    typedef struct packed {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic        rwm, rww, lde, pcs;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end else begin
            $display("ok   %s value=%0h", name, got);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        @(negedge iclk);
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcb0E, PCSrcE, MemReqM, MemReadyM} = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //         rs1d rs2d rs1e rs2e rde rdm rdw rwm rww lde pcs  FA FB sF sD sE sM fD fE fW
        vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 11'b10_01_0000000};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 11'b10_10_0000000};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 11'b00_00_0000000};
        vecs[3]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 11'b01_01_0000000};
        vecs[4]  = '{5'd0, 5'd0, 5'd9, 5'd4, 5'd0, 5'd9, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000000};
        vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b00_00_1100010};
        vecs[6]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b00_00_1100010};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b00_00_0000000};
        vecs[8]  = '{5'd7, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_0000000};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 11'b00_00_0000110};
        vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'b00_00_1100110};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 11'b00_00_0000000};

        // Reset state
        irst = 1'b1;
        clear_inputs();
        #1;
        chk("reset_outs", 32'(outs), 32'(IDLE));
        chk("reset_timeout", 32'(oMemTimeout), 32'd0);
        MemReqM = 1'b1;
        PCSrcE  = 1'b1;
        #1;
        chk("reset_pcsrc_memreq", 32'(outs), 32'(11'b0000_0000110));
        clear_inputs();
        @(negedge iclk);
        irst = 1'b0;
        step();

        // Combinational vector table
        for (int i = 0; i < 12; i++) begin
            {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} =
                {vecs[i].rs1d, vecs[i].rs2d, vecs[i].rs1e, vecs[i].rs2e,
                 vecs[i].rde, vecs[i].rdm, vecs[i].rdw};
            {RegWriteM, RegWriteW, ResultSrcb0E, PCSrcE} =
                {vecs[i].rwm, vecs[i].rww, vecs[i].lde, vecs[i].pcs};
            #1;
            chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            step();
        end
        clear_inputs();
        step();

        // 3-cycle memory wait with a branch pending in E
        MemReqM = 1'b1;
        PCSrcE  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("memwait_c%0d", c), 32'(outs), 32'(MEM_STALL));
            step();
        end
        MemReadyM = 1'b1;
        #1;
        chk("memwait_ready", 32'(outs), 32'(11'b0000_0000110));
        step();
        clear_inputs();
        #1;
        chk("memwait_after", 32'(outs), 32'(IDLE));
        step();

        // Timeout after MAX_WAIT=4 cycles
        MemReqM = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("tmo_stall_c%0d", c), 32'(outs), 32'(MEM_STALL));
            chk($sformatf("tmo_flag_c%0d", c), 32'(oMemTimeout), 32'd0);
            step();
        end
        #1;
        chk("tmo_release_outs", 32'(outs), 32'(IDLE));
        chk("tmo_flag_set", 32'(oMemTimeout), 32'd1);
        MemReqM = 1'b0;
        step();
        step();
        chk("tmo_flag_sticky", 32'(oMemTimeout), 32'd1);
        irst = 1'b1;
        #1;
        chk("tmo_flag_cleared", 32'(oMemTimeout), 32'd0);
        step();
        irst = 1'b0;
        step();

        // Asynchronous reset in the middle of a wait
        MemReqM = 1'b1;
        step();
        #1;
        chk("async_wait_stall", 32'(StallM), 32'd1);
        irst = 1'b1;
        #1;
        chk("async_reset_outs", 32'(outs), 32'(IDLE));
        clear_inputs();
        step();
        irst = 1'b0;
        step();

`ifdef HAZARD_PERF_CNT_EN
        // Counters: 2 load-use events, then a 3-cycle memory wait
        for (int k = 0; k < 2; k++) begin
            ResultSrcb0E = 1'b1;
            RdE  = 5'd7;
            Rs2D = 5'd7;
            step();
            clear_inputs();
            step();
        end
        MemReqM = 1'b1;
        step();
        step();
        step();
        MemReadyM = 1'b1;
        step();
        clear_inputs();
        #1;
        chk("perf_loaduse", oLoadUseCnt, 32'd2);
        chk("perf_stall", oStallCycles, 32'd5);
        chk("perf_flush0", oFlushCnt, 32'd0);
        PCSrcE = 1'b1;
        step();
        clear_inputs();
        #1;
        chk("perf_flush1", oFlushCnt, 32'd1);
        MemReqM = 1'b1;
        step();
        irst = 1'b1;
        #1;
        chk("perf_rst_stall", oStallCycles, 32'd0);
        chk("perf_rst_loaduse", oLoadUseCnt, 32'd0);
        chk("perf_rst_flush", oFlushCnt, 32'd0);
        chk("perf_rst_stallf", 32'(StallF), 32'd0);
        clear_inputs();
        step();
        irst = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
